// File: rtl/kbd_pkg.sv
// kbd_pkg - shared definitions for the keyboard-matrix interceptor.
//   PORTA/CRA/PORTB/CRB : PIA register-select encodings (pia1_rs_i values)
//   kbd_state_t         : watchdog state (IDLE, ACTIVE, CLEAR)
//   KBD_ROWS_MAX        : largest supported row count
//   KBD_RELEASED        : port B value with no key pressed
package kbd_pkg;

  localparam logic [1:0] PORTA = 2'd0;
  localparam logic [1:0] CRA   = 2'd1;
  localparam logic [1:0] PORTB = 2'd2;
  localparam logic [1:0] CRB   = 2'd3;

  localparam int         KBD_ROWS_MAX = 16;
  localparam logic [7:0] KBD_RELEASED = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    CLEAR  = 2'd2
  } kbd_state_t;

endpackage

// File: rtl/kbd_watchdog.sv
// kbd_watchdog - stuck-key watchdog for the keyboard matrix.
// Counts strobe cycles since the last accepted SPI matrix write and, when the
// host goes quiet for TIMEOUT_TICKS cycles, walks clear_ptr_o over every row
// so the top level can release the matrix one row per cycle.
// Ports:
//   strobe_clk_i  : clock, state advances on the falling edge
//   reset_i       : asynchronous active-high reset
//   spi_hit_i     : an SPI write to a valid matrix row this cycle
//   clear_done_i  : clear_ptr_o points at the last row
//   state_o       : current watchdog state
//   clear_ptr_o   : row being released while in CLEAR
module kbd_watchdog
  import kbd_pkg::*;
#(
  parameter int          ROW_AW        = 4,
  parameter logic [23:0] TIMEOUT_TICKS = 24'd1_000_000
) (
  input  logic              strobe_clk_i,
  input  logic              reset_i,
  input  logic              spi_hit_i,
  input  logic              clear_done_i,
  output kbd_state_t        state_o,
  output logic [ROW_AW-1:0] clear_ptr_o
);

  // A zero timeout disables the release path entirely.
  localparam bit          WD_EN  = (TIMEOUT_TICKS != 24'd0);
  localparam logic [23:0] RELOAD = TIMEOUT_TICKS - 24'd1;

  kbd_state_t        state_q, state_d;
  logic [23:0]       timer_q, timer_d;
  logic [ROW_AW-1:0] clear_ptr_q, clear_ptr_d;

  always_ff @(negedge strobe_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      IDLE: begin
        if (spi_hit_i) begin
          timer_d = RELOAD;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        // A write landing on the expiry cycle still counts as a refresh.
        if (spi_hit_i) begin
          timer_d = RELOAD;
        end else if (WD_EN) begin
          if (timer_q == 24'd0) begin
            clear_ptr_d = '0;
            state_d     = CLEAR;
          end else begin
            timer_d = timer_q - 24'd1;
          end
        end
      end
      CLEAR: begin
        if (clear_done_i) begin
          clear_ptr_d = '0;
          state_d     = IDLE;
        end else begin
          clear_ptr_d = clear_ptr_q + ROW_AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign clear_ptr_o = clear_ptr_q;

endmodule

// File: rtl/kbd_matrix_ctl.sv
// kbd_matrix_ctl - PET keyboard-matrix interceptor.
// Holds a ROWS x COLS key matrix written by the host over SPI, tracks the row
// the CPU selects through PIA1 port A, and presents that row on port B reads
// whenever it has a pressed key (active-low bits). A watchdog releases the
// matrix if the host stops refreshing it.
// Ports:
//   strobe_clk_i   : clock, all state updates on the falling edge
//   reset_i        : asynchronous active-high reset
//   spi_addr_i/spi_data_i/spi_wr_en_i : pending SPI write
//   pia1_en_i/pia1_rs_i               : PIA1 select and register select
//   bus_data_i     : CPU write data (row number on port A writes)
//   cpu_rd_en_i/cpu_wr_en_i           : CPU bus strobes
//   kbd_data_o     : registered port B data for the selected row
//   kbd_data_oe    : drive port B read data instead of the real keyboard
//   kbd_active_o   : watchdog in ACTIVE
//   kbd_clearing_o : watchdog in CLEAR
module kbd_matrix_ctl
  import kbd_pkg::*;
#(
  parameter int          ROWS          = 10,
  parameter int          COLS          = 8,
  parameter logic [16:0] SPI_BASE      = 17'h0E800,
  parameter logic [23:0] TIMEOUT_TICKS = 24'd1_000_000
) (
  input  logic        strobe_clk_i,
  input  logic        reset_i,
  input  logic [16:0] spi_addr_i,
  input  logic [7:0]  spi_data_i,
  input  logic        spi_wr_en_i,
  input  logic        pia1_en_i,
  input  logic [1:0]  pia1_rs_i,
  input  logic [7:0]  bus_data_i,
  input  logic        cpu_rd_en_i,
  input  logic        cpu_wr_en_i,
  output logic [7:0]  kbd_data_o,
  output logic        kbd_data_oe,
  output logic        kbd_active_o,
  output logic        kbd_clearing_o
);

  localparam int                ROW_AW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [4:0]        ROWS_W   = 5'(ROWS);
  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  logic [COLS-1:0]   rows_flat [ROWS];
  logic [ROW_AW-1:0] current_row_q, current_row_d;
  logic [7:0]        kbd_data_q, kbd_data_d;
  logic [7:0]        row_word;
  kbd_state_t        wd_state;
  logic [ROW_AW-1:0] clear_ptr;
  logic              spi_hit;
  logic              row_sel;
  logic              clearing;

  // Base match on the upper address bits; indices past the last row are ignored.
  assign spi_hit  = spi_wr_en_i
                 && (spi_addr_i[16:4] == SPI_BASE[16:4])
                 && ({1'b0, spi_addr_i[3:0]} < ROWS_W);
  assign row_sel  = cpu_wr_en_i && pia1_en_i && (pia1_rs_i == PORTA);
  assign clearing = (wd_state == CLEAR);

  kbd_watchdog #(
    .ROW_AW        (ROW_AW),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_watchdog (
    .strobe_clk_i  (strobe_clk_i),
    .reset_i       (reset_i),
    .spi_hit_i     (spi_hit),
    .clear_done_i  (clear_ptr == LAST_ROW),
    .state_o       (wd_state),
    .clear_ptr_o   (clear_ptr)
  );

  // One register per row; a CLEAR release takes precedence over SPI data,
  // and SPI writes during CLEAR are simply dropped.
  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [COLS-1:0] row_q;

      always_ff @(negedge strobe_clk_i or posedge reset_i) begin
        if (reset_i) begin
          row_q <= '1;
        end else if (clearing) begin
          if (clear_ptr == ROW_AW'(gi)) row_q <= '1;
        end else if (spi_hit && (spi_addr_i[3:0] == 4'(gi))) begin
          row_q <= spi_data_i[COLS-1:0];
        end
      end

      assign rows_flat[gi] = row_q;
    end
  endgenerate

  // Selected row padded with released bits; rows beyond the matrix read as
  // released, like a decoder output that selects nothing.
  always_comb begin
    row_word = KBD_RELEASED;
    for (int r = 0; r < ROWS; r++) begin
      if (current_row_q == ROW_AW'(r)) row_word[COLS-1:0] = rows_flat[r];
    end
  end

  // Only one action per cycle: CLEAR, then SPI, then row select, then refresh.
  always_comb begin
    current_row_d = current_row_q;
    kbd_data_d    = kbd_data_q;
    if (!clearing && !spi_hit) begin
      if (row_sel) current_row_d = bus_data_i[ROW_AW-1:0];
      else         kbd_data_d    = row_word;
    end
  end

  always_ff @(negedge strobe_clk_i or posedge reset_i) begin
    if (reset_i) begin
      current_row_q <= '0;
      kbd_data_q    <= KBD_RELEASED;
    end else begin
      current_row_q <= current_row_d;
      kbd_data_q    <= kbd_data_d;
    end
  end

  assign kbd_data_o     = kbd_data_q;
  assign kbd_data_oe    = cpu_rd_en_i && pia1_en_i && (pia1_rs_i == PORTB)
                       && (kbd_data_q != KBD_RELEASED);
  assign kbd_active_o   = (wd_state == ACTIVE);
  assign kbd_clearing_o = clearing;

  // Data bits above COLS and bus bits above the row index are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{spi_data_i, bus_data_i};

endmodule
